// File: rtl/frame_buffer_loader_pkg.sv
// Shared definitions for the frame buffer loader: geometry, sync marker,
// default timeout and FSM state encoding.
package frame_buffer_loader_pkg;

   localparam int         FB_ADDR_W      = 15;
   localparam int         FB_PIX_W       = 6;
   localparam logic [7:0] FB_SYNC_BYTE   = 8'hA5;
   localparam int         FB_TIMEOUT_CYC = 2_500_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

endpackage

// File: rtl/frame_buffer_loader_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port with
// read-before-write behaviour on address collision.
module frame_buffer_loader_dpram
   import frame_buffer_loader_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int PIX_W  = FB_PIX_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [PIX_W-1:0]  i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [PIX_W-1:0]  o_rd_data
);

   logic [PIX_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [PIX_W-1:0] r_rd_data;

   // Write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Read port: old contents on collision, output register cleared in reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frame_buffer_loader.sv
// Frames an incoming byte stream (sync byte + one full frame of pixels) into
// the frame RAM and serves the display read port.
module frame_buffer_loader
   import frame_buffer_loader_pkg::*;
#(
   parameter int         ADDR_W      = FB_ADDR_W,
   parameter int         PIX_W       = FB_PIX_W,
   parameter logic [7:0] SYNC_BYTE   = FB_SYNC_BYTE,
   parameter int         TIMEOUT_CYC = FB_TIMEOUT_CYC
) (
   input  logic              i_clk25M,
   input  logic              i_reset,
   input  logic [7:0]        i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [PIX_W-1:0]  o_rgb,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_frame_err
);

   localparam int                GAP_W     = $clog2(TIMEOUT_CYC);
   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   fb_state_e         r_state;
   fb_state_e         w_next_state;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [GAP_W-1:0]  r_gap;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_frame_err;

   logic              w_xfer;
   logic              w_we;
   logic              w_done_set;
   logic              w_err_set;

   assign w_xfer = i_in_valid & r_in_ready;
   // No writes on the reset edge so an aborted frame is left exactly as loaded
   assign w_we   = w_xfer & (r_state == ST_LOAD) & ~i_reset;

   // Next-state and pulse decode
   always_comb begin
      w_next_state = r_state;
      w_done_set   = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_xfer && (i_in_data == SYNC_BYTE)) begin
               w_next_state = ST_LOAD;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (w_xfer && (r_wr_addr == ADDR_LAST)) begin
               w_next_state = ST_DONE;
               w_done_set   = 1'b1;
            end else if (!w_xfer && (r_gap == GAP_MAX)) begin
               w_next_state = ST_IDLE;
               w_err_set    = 1'b1;
            end else begin
               w_next_state = ST_LOAD;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State and registered handshake/status outputs
   always_ff @(posedge i_clk25M) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_in_ready   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_in_ready   <= (w_next_state != ST_DONE);
         r_busy       <= (w_next_state == ST_LOAD);
         r_frame_done <= w_done_set;
         r_frame_err  <= w_err_set;
      end
   end

   // Write pointer and inter-byte gap counter, both parked at zero outside LOAD
   always_ff @(posedge i_clk25M) begin
      if (i_reset) begin
         r_wr_addr <= '0;
         r_gap     <= '0;
      end else if (r_state == ST_LOAD) begin
         if (w_xfer) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            r_gap     <= '0;
         end else begin
            r_gap     <= r_gap + 1'b1;
         end
      end else begin
         r_wr_addr <= '0;
         r_gap     <= '0;
      end
   end

   frame_buffer_loader_dpram #(
      .ADDR_W (ADDR_W),
      .PIX_W  (PIX_W)
   ) u_dpram (
      .i_clk     (i_clk25M),
      .i_rst     (i_reset),
      .i_we      (w_we),
      .i_wr_addr (r_wr_addr),
      .i_wr_data (i_in_data[PIX_W-1:0]),
      .i_rd_addr (i_addr),
      .o_rd_data (o_rgb)
   );

   assign o_in_ready   = r_in_ready;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_frame_buffer_loader.sv
// Self-checking bench for frame_buffer_loader against a frame-level reference
// model (pixel count, idle-cycle count, expected memory image).
module tb_frame_buffer_loader;

   localparam int TMO  = 1000;
   localparam int NPIX = 32768;

   logic        i_clk25M = 1'b0;
   logic        i_reset;
   logic [7:0]  i_in_data;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [14:0] i_addr;
   logic [5:0]  o_rgb;
   logic        o_busy;
   logic        o_frame_done;
   logic        o_frame_err;

   frame_buffer_loader #(
      .ADDR_W      (15),
      .PIX_W       (6),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .i_clk25M     (i_clk25M),
      .i_reset      (i_reset),
      .i_in_data    (i_in_data),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_addr       (i_addr),
      .o_rgb        (o_rgb),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_frame_err  (o_frame_err)
   );

   always #20 i_clk25M = ~i_clk25M;

   int n_cmp = 0;
   int n_err = 0;
   int done_seen = 0;
   int err_seen = 0;

   // Reference model state
   logic [5:0] ref_mem   [0:NPIX-1];
   bit         ref_known [0:NPIX-1];
   bit   m_loading = 1'b0;
   bit   m_done_cycle = 1'b0;
   int   m_count = 0;
   int   m_gap = 0;
   bit   m_ready = 1'b0;
   bit   m_busy = 1'b0;
   bit   m_done = 1'b0;
   bit   m_err = 1'b0;
   bit   m_accepted = 1'b0;
   logic [5:0] m_rgb = 6'h00;
   bit   m_rgb_known = 1'b1;

   typedef struct {
      logic [14:0] addr;
      logic [5:0]  rgb;
   } rd_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock edge of the reference: frame parsing by pixel and idle counts
   task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input logic [14:0] a);
      bit xfer;
      if (r) begin
         m_loading = 1'b0; m_done_cycle = 1'b0; m_count = 0; m_gap = 0;
         m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_rgb = 6'h00; m_rgb_known = 1'b1; m_accepted = 1'b0;
      end else begin
         m_rgb_known = ref_known[a];
         m_rgb = ref_mem[a];
         xfer = v && m_ready;
         m_accepted = xfer;
         m_done = 1'b0;
         m_err = 1'b0;
         if (m_done_cycle) begin
            m_done_cycle = 1'b0;
         end else if (!m_loading) begin
            if (xfer && d == 8'hA5) begin
               m_loading = 1'b1; m_count = 0; m_gap = 0;
            end
         end else if (xfer) begin
            ref_mem[m_count] = d[5:0];
            ref_known[m_count] = 1'b1;
            m_count++;
            m_gap = 0;
            if (m_count == NPIX) begin
               m_loading = 1'b0; m_done_cycle = 1'b1; m_done = 1'b1;
            end
         end else begin
            m_gap++;
            if (m_gap == TMO) begin
               m_loading = 1'b0; m_err = 1'b1;
            end
         end
         m_ready = !m_done_cycle;
         m_busy = m_loading;
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [7:0] d, input logic [14:0] a);
      i_reset = r; i_in_valid = v; i_in_data = d; i_addr = a;
      @(posedge i_clk25M);
      #1;
      model_edge(r, v, d, a);
      check("status{ready,busy,done,err}", {28'd0, o_in_ready, o_busy, o_frame_done, o_frame_err},
            {28'd0, m_ready, m_busy, m_done, m_err});
      if (m_rgb_known) check("rgb", {26'd0, o_rgb}, {26'd0, m_rgb});
      if (o_frame_done) done_seen++;
      if (o_frame_err) err_seen++;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic [14:0] a);
      int tries = 0;
      do begin
         step(1'b0, 1'b1, d, a);
         tries++;
      end while (!m_accepted && tries < 4);
      if (!m_accepted) begin
         n_cmp++; n_err++;
         $display("FAIL accept: byte 0x%0h not taken within %0d cycles", d, tries);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom), 15'($urandom));
   endtask

   initial begin
      rd_vec_t     tbl [8];
      logic [7:0]  d;
      logic [7:0]  first_b;
      logic [7:0]  b5_6;
      logic [7:0]  b99;
      logic [7:0]  b199;
      logic [14:0] a;
      int          err_at;

      for (int k = 0; k < NPIX; k++) begin
         ref_mem[k] = 6'h00;
         ref_known[k] = 1'b0;
      end
      tbl[0] = '{15'd0,     6'h00};
      tbl[1] = '{15'd63,    6'h3F};
      tbl[2] = '{15'd32767, 6'h3F};
      tbl[3] = '{15'd64,    6'h00};
      tbl[4] = '{15'd1,     6'h01};
      tbl[5] = '{15'd100,   6'h24};
      tbl[6] = '{15'd1000,  6'h28};
      tbl[7] = '{15'd16383, 6'h3F};

      // Reset state
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 8'hA5, 15'($urandom));
      check("reset_ready", {31'd0, o_in_ready}, 32'd0);
      check("reset_rgb", {26'd0, o_rgb}, 32'd0);

      // Full back-to-back frame, pixel = index[5:0], top bits random
      send_byte(8'hA5, 15'($urandom));
      for (int i = 0; i < NPIX; i++) begin
         d = 8'($urandom);
         d[5:0] = i[5:0];
         send_byte(d, 15'($urandom));
      end
      idle(2);
      check("t1_done_count", done_seen, 32'd1);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 8'h00, tbl[k].addr);
         check("tbl_rgb", {26'd0, o_rgb}, {26'd0, tbl[k].rgb});
      end

      // Garbage dropped, then a frame with random gaps below the timeout
      step(1'b0, 1'b1, 8'h00, 15'd0);
      step(1'b0, 1'b1, 8'hFF, 15'd0);
      step(1'b0, 1'b1, 8'h12, 15'd0);
      check("t2_busy_idle", {31'd0, o_busy}, 32'd0);
      send_byte(8'hA5, 15'd0);
      check("t2_busy_after_sync", {31'd0, o_busy}, 32'd1);
      first_b = 8'h00;
      for (int i = 0; i < NPIX; i++) begin
         if (i == 1000 || i == 20000) idle(TMO - 1);
         else if ($urandom_range(0, 31) == 0) idle($urandom_range(1, 10));
         d = 8'($urandom);
         if (i == 0) first_b = d;
         a = ($urandom_range(0, 1) == 0) ? 15'(m_count) : 15'($urandom);
         send_byte(d, a);
      end
      idle(2);
      check("t4_done_count", done_seen, 32'd2);
      check("t4_no_err", err_seen, 32'd0);
      step(1'b0, 1'b0, 8'h00, 15'd0);
      check("t2_mem0", {26'd0, o_rgb}, {26'd0, first_b[5:0]});

      // Timeout after 100 pixels
      send_byte(8'hA5, 15'd0);
      b99 = 8'h00;
      for (int i = 0; i < 100; i++) begin
         d = 8'($urandom);
         if (i == 99) b99 = d;
         send_byte(d, 15'($urandom));
      end
      err_at = 0;
      for (int k = 1; k <= TMO + 2; k++) begin
         step(1'b0, 1'b0, 8'h00, 15'($urandom));
         if (o_frame_err && err_at == 0) err_at = k;
      end
      check("t3_err_cycle", err_at, TMO);
      check("t3_busy", {31'd0, o_busy}, 32'd0);
      step(1'b0, 1'b0, 8'h00, 15'd99);
      check("t3_mem99", {26'd0, o_rgb}, {26'd0, b99[5:0]});

      // 0xA5 as data at pixel 5, then reset at pixel 200
      send_byte(8'hA5, 15'd0);
      b5_6 = 8'h00;
      b199 = 8'h00;
      for (int i = 0; i < 200; i++) begin
         d = (i == 5) ? 8'hA5 : 8'($urandom);
         if (i == 6) b5_6 = d;
         if (i == 199) b199 = d;
         send_byte(d, 15'($urandom));
      end
      step(1'b1, 1'b1, 8'h3C, 15'd200);
      check("t6_busy", {31'd0, o_busy}, 32'd0);
      check("t6_pulses", {30'd0, o_frame_done, o_frame_err}, 32'd0);
      step(1'b0, 1'b0, 8'h00, 15'd5);
      check("t5_mem5", {26'd0, o_rgb}, 32'h25);
      step(1'b0, 1'b0, 8'h00, 15'd6);
      check("t5_mem6", {26'd0, o_rgb}, {26'd0, b5_6[5:0]});
      step(1'b0, 1'b0, 8'h00, 15'd199);
      check("t6_mem199", {26'd0, o_rgb}, {26'd0, b199[5:0]});
      send_byte(8'hA5, 15'd0);
      send_byte(8'h07, 15'd0);
      step(1'b0, 1'b0, 8'h00, 15'd0);
      check("t6_restart_mem0", {26'd0, o_rgb}, 32'h07);
      check("t6_total_err", err_seen, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
